// File: rtl/pong_vga_renderer.sv
// 640x480@60 VGA renderer for pong: sync generation, per-frame game-state snapshot,
// and a single registered output stage for hsync/vsync/rgb/display_on/frame_tick.
module pong_vga_renderer #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int PADDLE_WIDTH  = 10,
  parameter int PADDLE_HEIGHT = 60,
  parameter int BALL_SIZE     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] player_paddle_y,
  input  logic [9:0] opponent_paddle_y,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] score,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       display_on,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last;

  logic [9:0] sh_player_y, sh_opponent_y, sh_ball_x, sh_ball_y;
  logic [7:0] sh_score;

  assign h_last = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last = (v_cnt == 10'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  logic vis, hs_active, vs_active, snap;
  assign vis       = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
  assign hs_active = (h_cnt >= 10'(H_VISIBLE + H_FP)) && (h_cnt < 10'(H_VISIBLE + H_FP + H_SYNC));
  assign vs_active = (v_cnt >= 10'(V_VISIBLE + V_FP)) && (v_cnt < 10'(V_VISIBLE + V_FP + V_SYNC));
  assign snap      = (h_cnt == 10'd0) && (v_cnt == 10'(V_VISIBLE));

  // Object bounds are evaluated in 11 bits so a shape near 1023 clips instead of wrapping.
  logic [10:0] h_ext, v_ext;
  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  logic ball_hit, left_hit, right_hit, tally_row, net_hit;
  assign ball_hit  = (h_ext >= {1'b0, sh_ball_x}) && (h_ext < {1'b0, sh_ball_x} + 11'(BALL_SIZE)) &&
                     (v_ext >= {1'b0, sh_ball_y}) && (v_ext < {1'b0, sh_ball_y} + 11'(BALL_SIZE));
  assign left_hit  = (h_cnt < 10'(PADDLE_WIDTH)) &&
                     (v_ext >= {1'b0, sh_opponent_y}) &&
                     (v_ext < {1'b0, sh_opponent_y} + 11'(PADDLE_HEIGHT));
  assign right_hit = (h_cnt >= 10'(H_VISIBLE - PADDLE_WIDTH)) &&
                     (v_ext >= {1'b0, sh_player_y}) &&
                     (v_ext < {1'b0, sh_player_y} + 11'(PADDLE_HEIGHT));
  assign tally_row = (v_cnt >= 10'd8) && (v_cnt <= 10'd15);
  assign net_hit   = ((h_cnt == 10'd319) || (h_cnt == 10'd320)) && !v_cnt[3];

  // Tally blocks are 8 px wide on a 12 px pitch, growing outward from the net.
  logic opp_hit, ply_hit;
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    opp_hit = 1'b0;
    ply_hit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if ((4'(k) < sh_score[7:4]) && (h_cnt >= 10'(304 - 12 * k)) && (h_cnt <= 10'(311 - 12 * k)))
        opp_hit = 1'b1;
      if ((4'(k) < sh_score[3:0]) && (h_cnt >= 10'(328 + 12 * k)) && (h_cnt <= 10'(335 + 12 * k)))
        ply_hit = 1'b1;
    end
  end

  logic [5:0] colour;
  always_comb begin
    colour = 6'b000000;
    if (ball_hit)                  colour = 6'b111100;
    else if (left_hit)             colour = 6'b111111;
    else if (right_hit)            colour = 6'b111111;
    else if (tally_row && opp_hit) colour = 6'b110000;
    else if (tally_row && ply_hit) colour = 6'b001100;
    else if (net_hit)              colour = 6'b101010;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_player_y   <= 10'd210;
      sh_opponent_y <= 10'd210;
      sh_ball_x     <= 10'd320;
      sh_ball_y     <= 10'd240;
      sh_score      <= 8'd0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      rgb           <= 6'b000000;
      display_on    <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      if (snap) begin
        sh_player_y   <= player_paddle_y;
        sh_opponent_y <= opponent_paddle_y;
        sh_ball_x     <= ball_x;
        sh_ball_y     <= ball_y;
        sh_score      <= score;
      end
      hsync      <= !hs_active;
      vsync      <= !vs_active;
      rgb        <= vis ? colour : 6'b000000;
      display_on <= vis;
      frame_tick <= snap;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Self-checking bench for pong_vga_renderer: a pixel-level model checked every cycle,
// plus literal expectations. Vertical timing is shortened so several frames fit in the run.
module tb_pong_vga_renderer;

  localparam int H_VIS = 640;
  localparam int H_TOT = 800;
  localparam int V_VIS = 32;
  localparam int V_FP  = 1;
  localparam int V_SY  = 2;
  localparam int V_BP  = 1;
  localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] player_paddle_y, opponent_paddle_y, ball_x, ball_y;
  logic [7:0] score;
  logic       hsync, vsync, display_on, frame_tick;
  logic [5:0] rgb;

  pong_vga_renderer #(
    .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .player_paddle_y(player_paddle_y), .opponent_paddle_y(opponent_paddle_y),
    .ball_x(ball_x), .ball_y(ball_y), .score(score),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .display_on(display_on), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int vs_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model state: position in frame, shadow copy of the game state, expected output bus.
  int         cyc = 0;
  int         p = 0;
  int         s_pp, s_op, s_bx, s_by, s_opp, s_ply;
  logic [9:0] exp_bus;
  bit         model_on = 0;

  function automatic logic [5:0] pixel(input int h, input int v);
    int d;
    if (h >= s_bx && h < s_bx + 10 && v >= s_by && v < s_by + 10) return 6'b111100;
    if (h < 10 && v >= s_op && v < s_op + 60) return 6'b111111;
    if (h >= H_VIS - 10 && v >= s_pp && v < s_pp + 60) return 6'b111111;
    if (v >= 8 && v <= 15) begin
      if (h <= 311) begin
        d = 311 - h;
        if (d % 12 < 8 && d / 12 < s_opp) return 6'b110000;
      end
      if (h >= 328) begin
        d = h - 328;
        if (d % 12 < 8 && d / 12 < s_ply) return 6'b001100;
      end
    end
    if ((h == 319 || h == 320) && ((v / 8) % 2 == 0)) return 6'b101010;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    int h, v;
    logic vis, hs, vs, ft;
    if (!rst_n) begin
      cyc = 0; p = 0;
      s_pp = 210; s_op = 210; s_bx = 320; s_by = 240; s_opp = 0; s_ply = 0;
      exp_bus = 10'b11_0_0_000000;
      model_on = 1;
    end else begin
      h   = p % H_TOT;
      v   = p / H_TOT;
      vis = (h < H_VIS) && (v < V_VIS);
      hs  = !(h >= 656 && h < 752);
      vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SY);
      ft  = (h == 0) && (v == V_VIS);
      exp_bus = {hs, vs, vis, ft, vis ? pixel(h, v) : 6'b000000};
      if (ft) begin
        s_pp = int'(player_paddle_y); s_op = int'(opponent_paddle_y);
        s_bx = int'(ball_x); s_by = int'(ball_y);
        s_opp = int'(score[7:4]); s_ply = int'(score[3:0]);
      end
      p = (p + 1) % FRAME;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cycle", {22'd0, hsync, vsync, display_on, frame_tick, rgb}, {22'd0, exp_bus});
      if (cyc >= 1 && cyc <= FRAME && !vsync) vs_low++;
    end
  end

  // Waits until the outputs for pixel index k (k-th enabled edge after release) are visible.
  task automatic wait_pix(input int k);
    int guard = 0;
    while (cyc != k + 1 && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k + 1) check("wait_timeout", cyc, k + 1);
  endtask

  task automatic pix(input string name, input int k, input logic [5:0] exp);
    wait_pix(k);
    check(name, rgb, exp);
  endtask

  task automatic hs_at(input string name, input int k, input logic exp);
    wait_pix(k);
    check(name, hsync, exp);
  endtask

  task automatic ft_at(input string name, input int k, input logic exp);
    wait_pix(k);
    check(name, frame_tick, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    player_paddle_y = 10'd210; opponent_paddle_y = 10'd210;
    ball_x = 10'd320; ball_y = 10'd240; score = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {hsync, vsync, display_on, frame_tick, rgb}, 10'b11_0_0_000000);
    rst_n = 1'b1;

    // Frame 1: reset shadow state, only the net is visible.
    pix("net_320_0", 320, 6'b101010);
    pix("after_net_321_0", 321, 6'b000000);
    hs_at("hs_before_fall", 655, 1'b1);
    hs_at("hs_fall", 656, 1'b0);
    hs_at("hs_last_low", 751, 1'b0);
    hs_at("hs_rise", 752, 1'b1);
    hs_at("hs_line2_before", 1455, 1'b1);
    hs_at("hs_line2_fall", 1456, 1'b0);
    pix("no_tally_score0", 6704, 6'b000000);
    pix("net_gap_320_8", 6720, 6'b000000);
    pix("net_319_16", 13119, 6'b101010);

    // New state arrives mid-frame; frame 1 must not change.
    wait_pix(19000);
    ball_x = 10'd100; ball_y = 10'd20;
    opponent_paddle_y = 10'd1000; player_paddle_y = 10'd10;
    score = 8'h31;
    pix("no_tear_frame1", 20100, 6'b000000);
    ft_at("ft_before", 25599, 1'b0);
    ft_at("ft_pulse", 25600, 1'b1);
    ft_at("ft_after", 25601, 1'b0);
    wait_pix(FRAME);
    check("vsync_low_per_frame", vs_low, 1600);

    // Frame 2 renders the snapshot.
    pix("left_paddle_no_wrap", FRAME, 6'b000000);
    wait_pix(FRAME + 4000);
    ball_x = 10'd200;
    pix("tally_gap_279", 35479, 6'b000000);
    pix("red_k1_292", 35492, 6'b110000);
    pix("tally_gap_300", 35500, 6'b000000);
    pix("red_k0_304", 35504, 6'b110000);
    pix("net_off_320_8", 35520, 6'b000000);
    pix("green_k0_328", 35528, 6'b001100);
    pix("no_green_k1_340", 35540, 6'b000000);
    pix("rpad_above_630_9", 36630, 6'b000000);
    pix("no_left_pad_5_10", 36805, 6'b000000);
    pix("rpad_left_629_10", 37429, 6'b000000);
    pix("rpad_630_10", 37430, 6'b111111);
    pix("red_k2_280_12", 38680, 6'b110000);
    pix("red_311_15", 41111, 6'b110000);
    pix("green_335_15", 41135, 6'b001100);
    pix("net_320_16", 41920, 6'b101010);
    pix("ball_100_20_old", 44900, 6'b111100);
    pix("ball_right_110_20", 44910, 6'b000000);
    pix("ball_109_29", 52109, 6'b111100);
    pix("ball_below_109_30", 52909, 6'b000000);
    pix("rpad_clip_639_31", 54239, 6'b111111);
    ft_at("ft_frame2", FRAME + 25600, 1'b1);

    // Frame 3 shows the ball_x change made during frame 2.
    pix("ball_moved_from_100", 73700, 6'b000000);
    pix("ball_now_200_20", 73800, 6'b111100);

    // Reset in the middle of an hsync pulse, then timing restarts from release.
    hs_at("hs_low_before_rst", 74300, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midline_reset_outputs", {hsync, vsync, display_on, frame_tick, rgb}, 10'b11_0_0_000000);
    rst_n = 1'b1;
    hs_at("rst_hs_before_fall", 655, 1'b1);
    hs_at("rst_hs_fall", 656, 1'b0);
    hs_at("rst_hs_last_low", 751, 1'b0);
    hs_at("rst_hs_rise", 752, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
